// File: rtl/mrc_pkg.sv
// Shared definitions for the multiply/divide/sqrt core: op encodings,
// controller states and the width-dependent iteration counts.
package mrc_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_X,
    ST_LOAD_Y,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_t;

  // Square root retires two operand bits per step, so it needs half the steps.
  function automatic int unsigned iter_count(input op_t op, input int unsigned w);
    return (op == OP_SQRT) ? (w / 2) : w;
  endfunction

endpackage

// File: rtl/mrc_iter_datapath.sv
// Iterative magnitude engine: shift-add multiply, restoring divide and
// digit-by-digit square root, all on unsigned operand magnitudes.
module mrc_iter_datapath
  import mrc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  op_t            op,
  input  logic           init,
  input  logic           step,
  input  logic [W-1:0]   mag_a,
  input  logic [W-1:0]   mag_b,
  output logic           done,
  output logic [2*W-1:0] res_mag
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc, acc_nx;
  logic [2*W-1:0] sh, sh_nx;
  logic [W-1:0]   mb, mb_nx;
  logic [CW-1:0]  cnt;
  logic [W:0]     div_shift, div_trial;
  logic [W+1:0]   sq_shift, sq_trial;

  // acc: product / partial remainder; sh: shifting multiplicand or dividend/radicand;
  // mb: multiplier, divisor, or the root being built.
  always_comb begin
    div_shift = {acc[W-1:0], sh[W-1]};
    div_trial = div_shift - {1'b0, mb};
    sq_shift  = {acc[W-1:0], sh[W-1:W-2]};
    sq_trial  = sq_shift - {mb, 2'b01};
    acc_nx    = acc;
    sh_nx     = sh;
    mb_nx     = mb;
    case (op)
      OP_MUL: begin
        if (mb[0]) acc_nx = acc + sh;
        sh_nx = {sh[2*W-2:0], 1'b0};
        mb_nx = {1'b0, mb[W-1:1]};
      end
      OP_DIV: begin
        if (!div_trial[W]) begin
          acc_nx = {{(W-1){1'b0}}, div_trial};
          sh_nx  = {sh[2*W-2:0], 1'b1};
        end else begin
          acc_nx = {{(W-1){1'b0}}, div_shift};
          sh_nx  = {sh[2*W-2:0], 1'b0};
        end
      end
      OP_SQRT: begin
        sh_nx = {sh[2*W-3:0], 2'b00};
        if (!sq_trial[W+1]) begin
          acc_nx = {{(W-2){1'b0}}, sq_trial};
          mb_nx  = {mb[W-2:0], 1'b1};
        end else begin
          acc_nx = {{(W-2){1'b0}}, sq_shift};
          mb_nx  = {mb[W-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    res_mag = acc;
    case (op)
      OP_DIV:  res_mag = {acc[W-1:0], sh[W-1:0]};
      OP_SQRT: res_mag = {acc[W-1:0], mb};
      default: ;
    endcase
  end

  assign done = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      sh  <= '0;
      mb  <= '0;
      cnt <= '0;
    end else if (init) begin
      acc <= '0;
      sh  <= {{W{1'b0}}, mag_a};
      mb  <= (op == OP_SQRT) ? '0 : mag_b;
      cnt <= CW'(iter_count(op, W));
    end else if (step) begin
      acc <= acc_nx;
      sh  <= sh_nx;
      mb  <= mb_nx;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mrc_multi_op.sv
// Sequential signed multiply/divide/sqrt unit: operand handshake over the
// shared Data bus, error pre-check, iteration and final sign correction.
module mrc_multi_op
  import mrc_pkg::*;
#(
  parameter int WORD_LENGTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     load,
  input  logic [WORD_LENGTH-1:0]   Data,
  input  logic [1:0]               op,
  output logic                     ready,
  output logic                     x,
  output logic                     y,
  output logic                     error,
  output logic [2*WORD_LENGTH-1:0] Result
);

  localparam int W = WORD_LENGTH;

  state_t         state, state_nx;
  op_t            op_reg;
  logic [W-1:0]   x_reg, y_reg;
  logic           pre_err;
  logic           start_ok, load_x, load_y, run_entry, err_chk;
  logic [W-1:0]   opnd_x, opnd_y;
  logic           dp_done;
  logic [2*W-1:0] res_mag, fix_result;
  logic [W-1:0]   quo_mag, rem_mag;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  // The final operand is fed straight from the bus so iteration can start on
  // the edge right after the load.
  always_comb begin
    start_ok  = start && (state == ST_IDLE || state == ST_DONE ||
                          state == ST_LOAD_X || state == ST_LOAD_Y);
    load_x    = load && !start_ok && (state == ST_LOAD_X);
    load_y    = load && !start_ok && (state == ST_LOAD_Y);
    run_entry = (load_x && op_reg == OP_SQRT) || load_y;
    opnd_x    = load_x ? Data : x_reg;
    opnd_y    = load_y ? Data : y_reg;
    err_chk   = 1'b0;
    case (op_reg)
      OP_DIV:  err_chk = (opnd_y == '0) ||
                         (opnd_x == {1'b1, {(W-1){1'b0}}} && opnd_y == '1);
      OP_SQRT: err_chk = opnd_x[W-1];
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (start_ok) begin
      state_nx = (op_t'(op) == OP_RSVD) ? ST_DONE : ST_LOAD_X;
    end else begin
      case (state)
        ST_LOAD_X: if (load_x) state_nx = (op_reg == OP_SQRT) ? ST_RUN : ST_LOAD_Y;
        ST_LOAD_Y: if (load_y) state_nx = ST_RUN;
        ST_RUN: begin
          if (pre_err)      state_nx = ST_DONE;
          else if (dp_done) state_nx = ST_FIX;
        end
        ST_FIX:  state_nx = ST_DONE;
        default: ;
      endcase
    end
  end

  mrc_iter_datapath #(.W(W)) u_dp (
    .clk     (clk),
    .reset   (reset),
    .op      (op_reg),
    .init    (run_entry),
    .step    (state == ST_RUN && !pre_err),
    .mag_a   (mag(opnd_x)),
    .mag_b   (mag(opnd_y)),
    .done    (dp_done),
    .res_mag (res_mag)
  );

  // Quotient takes the product of signs; remainder follows the dividend.
  always_comb begin
    quo_mag    = res_mag[W-1:0];
    rem_mag    = res_mag[2*W-1:W];
    fix_result = res_mag;
    case (op_reg)
      OP_MUL:  fix_result = (x_reg[W-1] ^ y_reg[W-1]) ? -res_mag : res_mag;
      OP_DIV:  fix_result = {(x_reg[W-1] ? -rem_mag : rem_mag),
                             ((x_reg[W-1] ^ y_reg[W-1]) ? -quo_mag : quo_mag)};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_reg  <= OP_MUL;
      x_reg   <= '0;
      y_reg   <= '0;
      pre_err <= 1'b0;
      error   <= 1'b0;
      Result  <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        op_reg  <= op_t'(op);
        x_reg   <= '0;
        y_reg   <= '0;
        pre_err <= 1'b0;
        error   <= (op_t'(op) == OP_RSVD);
        Result  <= '0;
      end else begin
        if (load_x)    x_reg   <= Data;
        if (load_y)    y_reg   <= Data;
        if (run_entry) pre_err <= err_chk;
        if (state == ST_RUN && pre_err) error  <= 1'b1;
        if (state == ST_FIX)            Result <= fix_result;
      end
    end
  end

  assign ready = (state == ST_DONE);
  assign x     = (state == ST_LOAD_X);
  assign y     = (state == ST_LOAD_Y);

endmodule

// File: tb/tb_mrc_multi_op.sv
// Directed-vector bench for mrc_multi_op at W = 16: arithmetic results,
// exact latencies, error pre-checks, handshake corner cases and reset.
module tb_mrc_multi_op;

  localparam logic [1:0] MUL = 2'b00, DIV = 2'b01, SQRT = 2'b10, RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        load = 1'b0;
  logic [15:0] Data = '0;
  logic [1:0]  op = 2'b00;
  logic        ready, x, y, error;
  logic [31:0] Result;

  int total = 0;
  int bad = 0;

  mrc_multi_op #(.WORD_LENGTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .load   (load),
    .Data   (Data),
    .op     (op),
    .ready  (ready),
    .x      (x),
    .y      (y),
    .error  (error),
    .Result (Result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic s, input logic l, input logic [1:0] o, input logic [15:0] d);
    @(negedge clk);
    start = s;
    load  = l;
    op    = o;
    Data  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    load  = 1'b0;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [15:0] xv,
                       input logic [15:0] yv, input int lat, input logic exp_err,
                       input logic [31:0] exp_res);
    applyStimulus(1'b1, 1'b0, o, 16'h0);
    checkOutput({tag, ".x"}, {63'd0, x}, 64'd1);
    applyStimulus(1'b0, 1'b1, o, xv);
    if (o != SQRT) begin
      checkOutput({tag, ".y"}, {63'd0, y}, 64'd1);
      applyStimulus(1'b0, 1'b1, o, yv);
    end else begin
      checkOutput({tag, ".noy"}, {63'd0, y}, 64'd0);
    end
    waitEdges(lat - 2);
    checkOutput({tag, ".early"}, {63'd0, ready}, 64'd0);
    waitEdges(1);
    checkOutput({tag, ".ready"}, {63'd0, ready}, 64'd1);
    checkOutput({tag, ".err"}, {63'd0, error}, {63'd0, exp_err});
    checkOutput({tag, ".res"}, {32'd0, Result}, {32'd0, exp_res});
    waitEdges(1);
    checkOutput({tag, ".hold"}, {31'd0, ready, Result}, {31'd0, 1'b1, exp_res});
  endtask

  initial begin
    waitEdges(2);
    checkOutput("reset.outs", {28'd0, ready, x, y, error}, 64'd0);
    checkOutput("reset.res", {32'd0, Result}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    runOp("mul_m3x7", MUL, 16'hFFFD, 16'd7, 18, 1'b0, 32'hFFFF_FFEB);
    runOp("mul_min", MUL, 16'h8000, 16'h8000, 18, 1'b0, 32'h4000_0000);
    runOp("div_100_m7", DIV, 16'd100, 16'hFFF9, 18, 1'b0, 32'h0002_FFF2);
    runOp("div_m100_7", DIV, 16'hFF9C, 16'd7, 18, 1'b0, 32'hFFFE_FFF2);
    runOp("sqrt_1000", SQRT, 16'd1000, 16'h0, 10, 1'b0, 32'h0027_001F);

    runOp("err_div0", DIV, 16'd50, 16'd0, 2, 1'b1, 32'h0);
    runOp("err_ovf", DIV, 16'h8000, 16'hFFFF, 2, 1'b1, 32'h0);
    runOp("err_sqrtneg", SQRT, 16'hFFFC, 16'h0, 2, 1'b1, 32'h0);

    applyStimulus(1'b1, 1'b0, RSVD, 16'h0);
    checkOutput("rsvd.flags", {60'd0, ready, error, x, y}, {60'd0, 4'b1100});
    checkOutput("rsvd.res", {32'd0, Result}, 64'd0);

    // start+load together while already waiting for X: start wins, no advance
    applyStimulus(1'b1, 1'b0, MUL, 16'h0);
    applyStimulus(1'b1, 1'b1, MUL, 16'd5);
    checkOutput("startload.xy", {62'd0, x, y}, 64'b10);

    // restart from LOAD_Y with sqrt
    applyStimulus(1'b0, 1'b1, MUL, 16'd9);
    checkOutput("restart.y", {63'd0, y}, 64'd1);
    runOp("restart_sqrt", SQRT, 16'd144, 16'h0, 10, 1'b0, 32'h0000_000C);

    // start during RUN is ignored
    applyStimulus(1'b1, 1'b0, MUL, 16'h0);
    applyStimulus(1'b0, 1'b1, MUL, 16'd123);
    applyStimulus(1'b0, 1'b1, MUL, 16'hFFFE);
    waitEdges(3);
    applyStimulus(1'b1, 1'b0, SQRT, 16'h0);
    checkOutput("runstart.x", {63'd0, x}, 64'd0);
    waitEdges(12);
    checkOutput("runstart.early", {63'd0, ready}, 64'd0);
    waitEdges(1);
    checkOutput("runstart.res", {31'd0, ready, Result}, {31'd0, 1'b1, 32'hFFFF_FF0A});

    // reset mid-RUN
    applyStimulus(1'b1, 1'b0, DIV, 16'h0);
    applyStimulus(1'b0, 1'b1, DIV, 16'd1000);
    applyStimulus(1'b0, 1'b1, DIV, 16'd3);
    waitEdges(5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset.outs", {28'd0, ready, x, y, error}, 64'd0);
    checkOutput("midreset.res", {32'd0, Result}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    runOp("post_reset_mul", MUL, 16'd5, 16'd5, 18, 1'b0, 32'h0000_0019);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mrc_multi_op.md
# mrc_multi_op

Parametrised, sequential signed arithmetic unit; next generation of the team's multiply/square-root core. Collects operands over the shared `Data` bus with an x/y load handshake, then performs signed multiply, signed divide, or integer square root by iteration, and reports ready/error. Sits between the one-shot-conditioned `start`/`load` pulses and the BCD display path, on the 5 MHz divided clock.

## Interface
- `WORD_LENGTH`, 16: operand width W. Must be even and ≥ 4.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle pulse that begins an operation.
- `load`  in  1: single-cycle pulse that samples `Data` as the current operand.
- `Data`  in  W: two's-complement operand.
- `op`  in  2: 00 multiply, 01 divide, 10 sqrt, 11 reserved; sampled only on accepted `start`.
- `ready`  out  1: result valid; held until next accepted `start`.
- `x`  out  1: waiting for operand X.
- `y`  out  1: waiting for operand Y.
- `error`  out  1: operation failed; valid while `ready` = 1.
- `Result`  out  2W: result word, defined below.

## Operation
- States: IDLE, LOAD_X, LOAD_Y, RUN, FIX, DONE.
- IDLE/DONE + `start` → LOAD_X. Latch `op`, clear `ready`, `error`, `Result`.
- LOAD_X + `load` → latch X. If op = sqrt → RUN, else → LOAD_Y.
- LOAD_Y + `load` → latch Y → RUN.
- op = 11 on `start` → DONE directly, `error` = 1, `Result` = 0.
- At RUN entry, pre-check errors → DONE with `error` = 1, `Result` = 0, no iteration:
  - divide with Y = 0;
  - divide with X = −2^(W−1) and Y = −1 (quotient overflow);
  - sqrt with X < 0.
- RUN iterates on magnitudes for N cycles. N = W for multiply (shift-add) and divide (restoring). N = W/2 for sqrt (digit-by-digit, 2 bits per step).
- FIX applies sign correction (one cycle) → DONE.
- Multiply: `Result` = signed 2W-bit product.
- Divide: quotient truncated toward zero in `Result[W-1:0]`; remainder, with the dividend's sign, in `Result[2W-1:W]`.
- Sqrt: root, zero-extended, in `Result[W-1:0]`; remainder X − root² in `Result[2W-1:W]`.
- Flags: `x` = (state == LOAD_X), `y` = (state == LOAD_Y), `ready` = (state == DONE).
- Simultaneous events and restarts:
  - `start` and `load` in the same cycle: `start` wins, `load` ignored.
  - `start` in LOAD_X/LOAD_Y restarts: back to LOAD_X, new `op` latched, operands discarded.
  - `start` in RUN/FIX is ignored.
  - `load` outside LOAD_X/LOAD_Y is ignored.
- `reset` in any state: next edge → IDLE, abandoning any operation in progress.

## Timing
- Reset values: state IDLE; `ready`, `x`, `y`, `error` = 0; `Result` = 0; internal registers = 0.
- `x` is high one edge after an accepted `start`. `y` is high one edge after X is loaded (non-sqrt).
- Latency: `ready` is high exactly N+2 edges after the edge sampling the final `load`. That is 1 edge to enter RUN, N RUN cycles, and 1 FIX cycle.
  - W = 16: multiply/divide 18, sqrt 10.
- Error pre-check path: `ready` and `error` are high 2 edges after the final `load`.
- `Result` and `error` are stable for the whole time `ready` = 1.

## Structure
- Package `mrc_pkg`: op encodings, state enum, and the W-dependent iteration counts. Reuse `mrc_pkg` rather than redefining these in the block.
- One sub-module, `mrc_iter_datapath`:
  - holds the magnitude registers, the accumulator/partial-remainder, and the step counter;
  - interface is `op`, `init`, `step`, `done`.
- `mrc_multi_op` holds the FSM, operand latches, the error pre-check, and FIX sign correction.

## Test plan
W = 16 for all scenarios.
- Multiply −3 × 7 → after 18 edges `ready` = 1, `error` = 0, `Result` = 32'hFFFF_FFEB. Also −32768 × −32768 → 32'h4000_0000.
- Divide 100 ÷ −7 → `Result` = 32'h0002_FFF2 (remainder 2, quotient −14). Also −100 ÷ 7 → 32'hFFFE_FFF2.
- Sqrt 1000, where `y` never asserts → after 10 edges `Result` = 32'h0027_001F (remainder 39, root 31).
- Errors, each giving `ready` = `error` = 1 and `Result` = 0 two edges after the final `load`:
  - divide by 0;
  - −32768 ÷ −1;
  - sqrt of −4;
  - op = 11, which reaches DONE one edge after `start`.
- Handshake:
  - `start` + `load` in the same cycle → only LOAD_X, no operand latched.
  - `start` while `y` = 1 with a new op = sqrt → back to LOAD_X, sqrt completes correctly.
  - `start` during RUN → ignored, original result delivered.
- `reset` asserted mid-RUN for one cycle → all outputs 0 next edge; a following fresh multiply 5 × 5 → 32'h0000_0019.
